// File: rtl/cpu_regfile_sb.sv
// Register file with a load scoreboard: two write ports, one dual-index registered read.
// Define CPU_REGFILE_BYPASS_EN to forward same-cycle write data into reads.
module cpu_regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_a_en_i,
  input  logic [ADDR_W-1:0]        wr_a_idx_i,
  input  logic [DATA_W-1:0]        wr_a_data_i,
  input  logic                     wr_b_en_i,
  input  logic [ADDR_W-1:0]        wr_b_idx_i,
  input  logic [DATA_W-1:0]        wr_b_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_idx_i,
  input  logic                     rd_en_i,
  input  logic [ADDR_W-1:0]        rd_idx1_i,
  input  logic [ADDR_W-1:0]        rd_idx2_i,
  output logic [DATA_W-1:0]        value1_o,
  output logic [DATA_W-1:0]        value2_o,
  output logic                     rd_valid_o,
  output logic                     rd_busy_o,
  output logic [(2**ADDR_W)-1:0]   busy_o,
  output logic                     waw_err_o
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] value1_q, value1_d;
  logic [DATA_W-1:0] value2_q, value2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_busy_q, rd_busy_d;
  logic              waw_err_q, waw_err_d;

  logic [DATA_W-1:0] rd1_data, rd2_data;
  logic              rd1_busy, rd2_busy;

  // Read-side view of the array; port A outranks port B when forwarding.
  always_comb begin
    rd1_data = regs_q[rd_idx1_i];
    rd2_data = regs_q[rd_idx2_i];
    rd1_busy = busy_q[rd_idx1_i];
    rd2_busy = busy_q[rd_idx2_i];
`ifdef CPU_REGFILE_BYPASS_EN
    if (wr_b_en_i && (wr_b_idx_i == rd_idx1_i)) begin
      rd1_data = wr_b_data_i;
      rd1_busy = 1'b0;
    end
    if (wr_b_en_i && (wr_b_idx_i == rd_idx2_i)) begin
      rd2_data = wr_b_data_i;
      rd2_busy = 1'b0;
    end
    if (wr_a_en_i && (wr_a_idx_i == rd_idx1_i)) rd1_data = wr_a_data_i;
    if (wr_a_en_i && (wr_a_idx_i == rd_idx2_i)) rd2_data = wr_a_data_i;
`endif
  end

  // Next-state: B written before A so A wins a collision; release before reserve so reserve wins.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    value1_d   = value1_q;
    value2_d   = value2_q;
    rd_valid_d = rd_en_i;
    rd_busy_d  = rd_busy_q;
    waw_err_d  = waw_err_q | (wr_a_en_i & busy_q[wr_a_idx_i]);
    if (wr_b_en_i) begin
      regs_d[wr_b_idx_i] = wr_b_data_i;
      busy_d[wr_b_idx_i] = 1'b0;
    end
    if (wr_a_en_i) regs_d[wr_a_idx_i] = wr_a_data_i;
    if (rsv_en_i) busy_d[rsv_idx_i] = 1'b1;
    if (rd_en_i) begin
      value1_d  = rd1_data;
      value2_d  = rd2_data;
      rd_busy_d = rd1_busy | rd2_busy;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      value1_q   <= '0;
      value2_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_busy_q  <= 1'b0;
      waw_err_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      value1_q   <= value1_d;
      value2_q   <= value2_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
      waw_err_q  <= waw_err_d;
    end
  end

  assign value1_o   = value1_q;
  assign value2_o   = value2_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_busy_o  = rd_busy_q;
  assign busy_o     = busy_q;
  assign waw_err_o  = waw_err_q;

endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Self-checking bench for cpu_regfile_sb: directed vector table, reset sequence, random vs. model.
module tb_cpu_regfile_sb;

`ifdef CPU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wa_en, wb_en, rsv_en, rd_en;
  logic [3:0]  wa_idx, wb_idx, rsv_idx, i1, i2;
  logic [31:0] wa_data, wb_data;
  logic [31:0] value1, value2;
  logic        rd_valid, rd_busy, waw_err;
  logic [15:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_regfile_sb #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_a_en_i(wa_en), .wr_a_idx_i(wa_idx), .wr_a_data_i(wa_data),
    .wr_b_en_i(wb_en), .wr_b_idx_i(wb_idx), .wr_b_data_i(wb_data),
    .rsv_en_i(rsv_en), .rsv_idx_i(rsv_idx),
    .rd_en_i(rd_en), .rd_idx1_i(i1), .rd_idx2_i(i2),
    .value1_o(value1), .value2_o(value2),
    .rd_valid_o(rd_valid), .rd_busy_o(rd_busy),
    .busy_o(busy), .waw_err_o(waw_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wa_en; logic [3:0] wa_idx; logic [31:0] wa_data;
    logic        wb_en; logic [3:0] wb_idx; logic [31:0] wb_data;
    logic        rsv_en; logic [3:0] rsv_idx;
    logic        rd_en; logic [3:0] i1; logic [3:0] i2;
    logic [31:0] e_v1; logic [31:0] e_v2;
    logic        e_valid; logic e_rb; logic e_waw; logic [15:0] e_busy;
  } vec_t;

  vec_t vecs [16];

  // Reference model state
  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  logic [31:0] m_v1, m_v2;
  logic        m_valid, m_rb, m_waw;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] v1, input logic [31:0] v2,
                         input logic vl, input logic rb, input logic ww, input logic [15:0] bz);
    chk({tag, ".value1"},   64'(value1),   64'(v1));
    chk({tag, ".value2"},   64'(value2),   64'(v2));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(vl));
    chk({tag, ".rd_busy"},  64'(rd_busy),  64'(rb));
    chk({tag, ".waw_err"},  64'(waw_err),  64'(ww));
    chk({tag, ".busy"},     64'(busy),     64'(bz));
  endtask

  task automatic idle_inputs();
    wa_en = 0; wa_idx = 0; wa_data = 0;
    wb_en = 0; wb_idx = 0; wb_data = 0;
    rsv_en = 0; rsv_idx = 0;
    rd_en = 0; i1 = 0; i2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0; m_v1 = '0; m_v2 = '0; m_valid = 0; m_rb = 0; m_waw = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] idx);
    if (BYP && wa_en && wa_idx == idx) return wa_data;
    if (BYP && wb_en && wb_idx == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic model_busy(input logic [3:0] idx);
    if (BYP && wb_en && wb_idx == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  // Apply one edge's worth of rules to the model from the currently driven inputs.
  task automatic model_edge();
    logic [31:0] r1, r2;
    logic        b;
    r1 = model_read(i1);
    r2 = model_read(i2);
    b  = model_busy(i1) || model_busy(i2);
    if (wa_en && m_busy[wa_idx]) m_waw = 1;
    m_valid = rd_en;
    if (rd_en) begin m_v1 = r1; m_v2 = r2; m_rb = b; end
    if (wb_en) begin m_regs[wb_idx] = wb_data; m_busy[wb_idx] = 0; end
    if (wa_en) m_regs[wa_idx] = wa_data;
    if (rsv_en) m_busy[rsv_idx] = 1;
  endtask

  initial begin
    //          waE idx  data            wbE idx  data           rsv idx  rd  i1   i2   v1              v2              vl rb ww busy
    vecs[0]  = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd0, 4'd15, 32'h0,        32'h0,        1, 0, 0, 16'h0};
    vecs[1]  = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 0, 4'd0, 4'd0,  32'h0,        32'h0,        0, 0, 0, 16'h0};
    vecs[2]  = '{1, 4'd3, 32'hDEADBEEF,  0, 4'd0, 32'h0,          0, 4'd0, 0, 4'd0, 4'd0,  32'h0,        32'h0,        0, 0, 0, 16'h0};
    vecs[3]  = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd3, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 16'h0};
    vecs[4]  = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd3, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 16'h0};
    vecs[5]  = '{1, 4'd5, 32'h11,        1, 4'd5, 32'h22,         0, 4'd0, 0, 4'd0, 4'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 16'h0};
    vecs[6]  = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd5, 4'd5,  32'h11,       32'h11,       1, 0, 0, 16'h0};
    vecs[7]  = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          1, 4'd7, 0, 4'd0, 4'd0,  32'h11,       32'h11,       0, 0, 0, 16'h0080};
    vecs[8]  = '{1, 4'd7, 32'h1234,      0, 4'd0, 32'h0,          0, 4'd0, 0, 4'd0, 4'd0,  32'h11,       32'h11,       0, 0, 1, 16'h0080};
    vecs[9]  = '{0, 4'd0, 32'h0,         1, 4'd7, 32'h55,         0, 4'd0, 0, 4'd0, 4'd0,  32'h11,       32'h11,       0, 0, 1, 16'h0};
    vecs[10] = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd7, 4'd3,  32'h55,       32'hDEADBEEF, 1, 0, 1, 16'h0};
    vecs[11] = '{1, 4'd2, 32'hAA,        0, 4'd0, 32'h0,          1, 4'd2, 0, 4'd0, 4'd0,  32'h55,       32'hDEADBEEF, 0, 0, 1, 16'h0004};
    vecs[12] = '{0, 4'd0, 32'h0,         1, 4'd2, 32'h99,         0, 4'd0, 1, 4'd2, 4'd2,
                 BYP ? 32'h99 : 32'hAA,  BYP ? 32'h99 : 32'hAA,   1, !BYP, 1, 16'h0};
    vecs[13] = '{0, 4'd0, 32'h0,         0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd2, 4'd2,  32'h99,       32'h99,       1, 0, 1, 16'h0};
    vecs[14] = '{0, 4'd0, 32'h0,         1, 4'd2, 32'h66,         1, 4'd2, 0, 4'd0, 4'd0,  32'h99,       32'h99,       0, 0, 1, 16'h0004};
    vecs[15] = '{1, 4'd2, 32'h77,        0, 4'd0, 32'h0,          0, 4'd0, 1, 4'd2, 4'd0,
                 BYP ? 32'h77 : 32'h66,  32'h0,                   1, 1, 1, 16'h0004};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 0, 0, 0, 16'h0);
    rst = 0;

    // Directed table
    for (int r = 0; r < 16; r++) begin
      wa_en = vecs[r].wa_en; wa_idx = vecs[r].wa_idx; wa_data = vecs[r].wa_data;
      wb_en = vecs[r].wb_en; wb_idx = vecs[r].wb_idx; wb_data = vecs[r].wb_data;
      rsv_en = vecs[r].rsv_en; rsv_idx = vecs[r].rsv_idx;
      rd_en = vecs[r].rd_en; i1 = vecs[r].i1; i2 = vecs[r].i2;
      step();
      chk_all($sformatf("vec%0d", r), vecs[r].e_v1, vecs[r].e_v2, vecs[r].e_valid,
              vecs[r].e_rb, vecs[r].e_waw, vecs[r].e_busy);
    end

    // Async reset mid-cycle clears a reservation and an in-flight read
    idle_inputs();
    rsv_en = 1; rsv_idx = 4'd4; rd_en = 1; i1 = 4'd2; i2 = 4'd3;
    step();
    chk("pre_rst.busy4", 64'(busy[4]), 64'(1));
    chk("pre_rst.valid", 64'(rd_valid), 64'(1));
    idle_inputs();
    #2 rst = 1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 0, 0, 0, 16'h0);
    @(posedge clk);
    #1 rst = 0;
    chk_all("rst_held", 32'h0, 32'h0, 0, 0, 0, 16'h0);
    rd_en = 1; i1 = 4'd4; i2 = 4'd3;
    step();
    chk_all("post_rst_rd", 32'h0, 32'h0, 1, 0, 0, 16'h0);
    idle_inputs();
    step();
    chk("post_rst.valid_drop", 64'(rd_valid), 64'(0));

    // Random stimulus against the model, with occasional asynchronous resets
    rst = 1;
    #1 rst = 0;
    model_reset();
    for (int k = 0; k < 2000; k++) begin
      wa_en   = ($urandom_range(0, 2) == 0);
      wb_en   = ($urandom_range(0, 2) == 0);
      rsv_en  = ($urandom_range(0, 3) == 0);
      rd_en   = ($urandom_range(0, 1) == 0);
      wa_idx  = 4'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      wb_idx  = 4'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      rsv_idx = 4'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      i1      = 4'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      i2      = 4'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      wa_data = $urandom;
      wb_data = $urandom;
      model_edge();
      step();
      chk_all($sformatf("rnd%0d", k), m_v1, m_v2, m_valid, m_rb, m_waw, m_busy);
      if (k % 250 == 249) begin
        #2 rst = 1;
        #1 rst = 0;
        model_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_regfile_sb.md
CPU_REGFILE_SB -- requirements
Module: cpu_regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register and data-port width in bits; legal range 8..64.
REQ-002 Parameter ADDR_W, default 4: register index width; the block SHALL hold NREGS = 2**ADDR_W registers.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 wr_a_en_i / wr_a_idx_i / wr_a_data_i  in  1 / ADDR_W / DATA_W  ALU write port.
REQ-006 wr_b_en_i / wr_b_idx_i / wr_b_data_i  in  1 / ADDR_W / DATA_W  load-return write port.
REQ-007 rsv_en_i / rsv_idx_i  in  1 / ADDR_W  reserve a register for an outstanding load.
REQ-008 rd_en_i / rd_idx1_i / rd_idx2_i  in  1 / ADDR_W / ADDR_W  read request and its two indices.
REQ-009 value1_o / value2_o  out  DATA_W each  registered read data.
REQ-010 rd_valid_o  out  1  one-cycle pulse marking fresh read data.
REQ-011 rd_busy_o  out  1  registered flag: an indexed register was reserved when the read was sampled.
REQ-012 busy_o  out  NREGS  scoreboard; bit i is 1 while register i is reserved.
REQ-013 waw_err_o  out  1  sticky flag: a port-A write hit a reserved register.

Function
REQ-014 Writes: each enabled port SHALL write its data to its index at the clock edge.
REQ-015 Write collision: if both ports write the same index in one cycle, port A data SHALL be stored.
REQ-016 Read: when rd_en_i=1 at an edge, value1_o and value2_o SHALL load the registers at rd_idx1_i and rd_idx2_i, and rd_valid_o SHALL be 1 for the following cycle only.
REQ-017 Read hold: when rd_en_i=0, value1_o and value2_o SHALL hold their values and rd_valid_o SHALL be 0.
REQ-018 Reserve: rsv_en_i=1 SHALL set busy_o[rsv_idx_i] at the edge.
REQ-019 Release: a port-B write SHALL clear busy_o[wr_b_idx_i].
REQ-020 Reserve/release collision: a same-cycle reserve and port-B write to the same index SHALL leave the bit set.
REQ-021 Port-A writes SHALL NOT change busy_o.
REQ-022 WAW error: a port-A write to a register whose bit is already set SHALL set waw_err_o, which stays 1 until reset.
REQ-023 rd_busy_o SHALL load, on each read edge, the OR of the pre-edge busy bits of both read indices, evaluated per REQ-027/REQ-028.
REQ-024 Reads of the same index on both read ports SHALL return identical data.
REQ-025 Read latency SHALL be exactly one cycle; back-to-back reads on consecutive cycles SHALL be supported, with rd_valid_o held high throughout.

Reset
REQ-026 While rst_i=1, all registers, value1_o, value2_o, busy_o, rd_valid_o, rd_busy_o and waw_err_o SHALL be 0; reset SHALL take effect without a clock edge, and pending reservations and in-flight reads SHALL be discarded.

Configuration
REQ-027 With macro CPU_REGFILE_BYPASS_EN defined:
- a read whose index matches a same-cycle write SHALL return the write data, with port A taking precedence per REQ-015;
- a same-cycle port-B write to a read index SHALL count as not busy for rd_busy_o.
REQ-028 With CPU_REGFILE_BYPASS_EN undefined:
- reads SHALL return the pre-edge register contents;
- rd_busy_o SHALL use the pre-edge busy bits unmodified.

Verification
REQ-029 Reset, then read r0/r15 -> value1_o=value2_o=0, rd_valid_o pulses once, busy_o=0.
REQ-030 Port A writes 0xDEADBEEF to idx 3; read idx 3 and idx 3 next cycle -> both outputs 0xDEADBEEF one cycle later.
REQ-031 Port A writes 0x11 and port B writes 0x22 to idx 5 in the same cycle, then read idx 5 -> 0x11.
REQ-032 Reserve idx 7, then port-A write to idx 7 -> waw_err_o=1 and stays 1; port-B write 0x55 to idx 7 -> busy_o[7]=0.
REQ-033 Idx 2 holds 0xAA; port-B writes 0x99 to idx 2 in the same cycle as a read of idx 2:
- with bypass: value 0x99, rd_busy_o=0;
- without bypass: value 0xAA, rd_busy_o=1 if idx 2 was reserved.
REQ-034 Reserve idx 4, then assert rst_i mid-cycle -> busy_o, waw_err_o and outputs clear immediately; after release, a read of idx 4 returns 0.
